// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with a one-word output register.
// Latency: p_valid rises one clock after the edge that samples the final bit of a word.
// Backpressure: a word completed while the output is still unconsumed is dropped and flags overrun.
// Optional macro SIPO_DESER_PARITY_EN: adds a trailing even-parity bit per word and a parity_err output.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
`ifdef SIPO_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             overrun_q, overrun_d;
`ifdef SIPO_DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
  logic             perr_new;
`endif

  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             ovr_set;

  // Next-state logic: bit assembly, word completion, output handshake and sticky overrun.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shift = {sr_q[WIDTH-2:0], s_in};
    end else begin
      sr_shift = {s_in, sr_q[WIDTH-1:1]};
    end

    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    overrun_d = overrun_q;
    word      = sr_shift;
    complete  = 1'b0;
    ovr_set   = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    parity_err_d = parity_err_q;
    perr_new     = 1'b0;
`endif

    if (s_en) begin
      case (state_q)
        COLLECT: begin
          sr_d = sr_shift;
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
`ifdef SIPO_DESER_PARITY_EN
            // All data bits are in; the next strobed bit is the parity bit.
            state_d = PARITY;
`else
            complete = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          // Data word is already complete in sr; this bit only feeds the parity check.
          word     = sr_q;
          complete = 1'b1;
          state_d  = COLLECT;
`ifdef SIPO_DESER_PARITY_EN
          perr_new = ^{sr_q, s_in};
`endif
        end
        default: state_d = COLLECT;
      endcase
    end

    if (complete) begin
      // A pop on the same edge frees the register, so the new word is taken without a bubble.
      if (!p_valid_q || p_ready) begin
        p_out_d   = word;
        p_valid_d = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
        parity_err_d = perr_new;
`endif
      end else begin
        ovr_set = 1'b1;
      end
    end else if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end

    // A new overrun wins over a clear on the same edge.
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= COLLECT;
      sr_q      <= '0;
      cnt_q     <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
`ifdef SIPO_DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign overrun = overrun_q;
`ifdef SIPO_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data bits per word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning the first received bit lands in p_out[WIDTH-1] (0: it lands in p_out[0]).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port s_in, input, 1, serial data bit.
REQ-006 SHALL have port s_en, input, 1, bit strobe; s_in is sampled only on edges where s_en=1.
REQ-007 SHALL have port p_out, output, WIDTH, the assembled parallel word (registered).
REQ-008 SHALL have port p_valid, output, 1, p_out holds an unconsumed word.
REQ-009 SHALL have port p_ready, input, 1, consumer accepts p_out on edges where p_valid=1 and p_ready=1.
REQ-010 SHALL have port overrun, output, 1, sticky flag: a completed word was dropped.
REQ-011 SHALL have port ovr_clr, input, 1, clears overrun.

Function
REQ-012 SHALL keep a shift register sr[WIDTH-1:0] and a bit counter cnt (0..WIDTH-1); each s_en=1 edge shifts s_in in (left shift into sr[0] if MSB_FIRST=1, else right shift into sr[WIDTH-1]) and increments cnt.
REQ-013 SHALL run states COLLECT and, only with the macro, PARITY; without the macro, the design is always in COLLECT.
REQ-014 SHALL treat the edge on which s_en=1 and cnt=WIDTH-1 as word completion; cnt wraps to 0 on that same edge.
REQ-015 SHALL on completion load the full word (including the bit sampled that edge) into p_out and set p_valid, with a latency of exactly one clock: p_valid=1 in the cycle after the final s_en.
REQ-016 SHALL clear p_valid on an edge where p_valid=1 and p_ready=1 and no completion occurs.
REQ-017 SHALL on simultaneous completion and pop load the new word and keep p_valid=1 (no bubble, no overrun).
REQ-018 SHALL on completion while p_valid=1 and p_ready=0 keep p_out unchanged, discard the new word, and set overrun.
REQ-019 SHALL hold sr, cnt, and state when s_en=0; p_out SHALL never change while p_valid=1 and p_ready=0.
REQ-020 SHALL clear overrun when ovr_clr=1; set wins if a set and ovr_clr occur on the same edge.
REQ-021 SHALL ignore p_ready while p_valid=0.

Reset
REQ-022 SHALL, on any edge with rst=0, force p_out=0, p_valid=0, overrun=0, sr=0, cnt=0, and state COLLECT, regardless of s_en, p_ready, or a partial word.
REQ-023 SHALL discard a partially assembled word on reset; the first s_en after reset release is bit 0 of a new word.

Configuration
REQ-024 SHALL support the macro SIPO_DESER_PARITY_EN; when it is undefined, the port list and behaviour are exactly as given in REQ-001 to REQ-023.
REQ-025 SHALL, with SIPO_DESER_PARITY_EN defined, enter PARITY after the WIDTH-th data bit instead of completing; the next s_en bit is an even-parity bit, and completion (REQ-015 to REQ-018) occurs on that edge, which then returns the design to COLLECT.
REQ-026 SHALL, with SIPO_DESER_PARITY_EN defined, add output parity_err (1 bit, registered), which is loaded together with p_out and equals 1 when the XOR of the data bits and the parity bit is 1; it resets to 0.

Verification
REQ-027 Bench SHALL apply WIDTH=4, MSB_FIRST=1, with s_en=1 for 4 edges carrying bits 1,0,1,1, and check p_out=4'b1011 with p_valid=1 exactly one cycle after the fourth bit.
REQ-028 Bench SHALL apply MSB_FIRST=0 with the same bits 1,0,1,1 and check p_out=4'b1101.
REQ-029 Bench SHALL, with p_ready=0, send 1011 then 0110, and check p_out stays 4'b1011, overrun=1, then pulse ovr_clr and check overrun=0.
REQ-030 Bench SHALL hold p_ready=1 and stream 1011 and 0110 back-to-back with s_en=1 continuously, and check that p_valid pulses for one cycle per word, with p_out=1011 and then 0110, and overrun=0.
REQ-031 Bench SHALL send 2 bits, assert rst=0 for one edge, then send 0110, and check p_out=4'b0110 with no stale bits.
REQ-032 Bench SHALL, with SIPO_DESER_PARITY_EN defined, send 1011 plus parity bit 1 and check parity_err=0, then send 1011 plus parity bit 0 and check parity_err=1.
